// File: rtl/layer_vec_collector.sv
// Serial-to-parallel activation collector: gathers N_IN words from a valid/ready stream
// into one of two ping-pong banks and presents full banks as a parallel vector.
module layer_vec_collector #(
  parameter int N_IN  = 15,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [N_IN*WIDTH-1:0] out_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err,
  output logic [CNT_W-1:0]      frame_cnt
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [WIDTH-1:0] bank_q [2][N_IN];
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             frame_err_q, frame_err_d;

  logic accept_s;
  logic last_slot_s;
  logic complete_s;
  logic early_s;
  logic release_s;

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

  assign accept_s    = in_valid & ~full_q[wr_bank_q];
  assign last_slot_s = (wr_idx_q == IDX_W'(N_IN - 1));
  assign complete_s  = accept_s & last_slot_s;
  assign early_s     = accept_s & in_last & ~last_slot_s;
  assign release_s   = full_q[rd_bank_q] & out_ready;

  for (genvar k = 0; k < N_IN; k++) begin : g_out
    assign out_vec[k*WIDTH +: WIDTH] = bank_q[rd_bank_q][k];
  end

  // Next-state for bank bookkeeping; release and completion always hit different banks
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_idx_d    = wr_idx_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = 1'b0;

    if (release_s) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      frame_cnt_d       = frame_cnt_q + CNT_W'(1);
    end else begin
      rd_bank_d = rd_bank_q;
    end

    if (complete_s) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
      wr_idx_d          = '0;
      frame_err_d       = ~in_last;
    end else if (early_s) begin
      wr_idx_d    = '0;
      frame_err_d = 1'b1;
    end else if (accept_s) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
    end else begin
      wr_idx_d = wr_idx_q;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      frame_cnt_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      frame_cnt_q <= frame_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Word storage; an early-last word is still written, the frame is simply never committed
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N_IN; k++) begin
          bank_q[b][k] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (accept_s && (wr_idx_q == IDX_W'(k))) begin
          bank_q[wr_bank_q][k] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_vec_collector.sv
// Scoreboard bench for layer_vec_collector: the driver models framing rules with a word queue
// and pushes expected vectors; a monitor checks handshakes and pops on every delivery.
module tb_layer_vec_collector;

  localparam int N  = 15;
  localparam int W  = 32;
  localparam int CW = 16;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [VW-1:0] out_vec;
  logic          out_valid;
  logic          out_ready;
  logic          frame_err;
  logic [CW-1:0] frame_cnt;

  layer_vec_collector #(.N_IN(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [VW-1:0] exp_q [$];
  logic [W-1:0]  cur [$];
  logic          err_exp  = 1'b0;
  logic [CW-1:0] cnt_exp  = '0;
  logic          mon_en   = 1'b0;
  logic          rst_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Framing rules: N words form a frame; a last flag before the Nth word throws the frame away
  task automatic model_word(input logic [W-1:0] d, input logic l);
    logic [VW-1:0] v;
    cur.push_back(d);
    if (cur.size() == N) begin
      v = '0;
      for (int k = 0; k < N; k++) v[k*W +: W] = cur[k];
      exp_q.push_back(v);
      err_exp = ~l;
      cur.delete();
    end else if (l) begin
      err_exp = 1'b1;
      cur.delete();
    end
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic l,
                       input logic ordy, input logic r, output logic acc);
    in_valid = v; in_data = d; in_last = l; out_ready = ordy; rst = r;
    @(negedge clk);
    if (rst_prev) begin
      chkv("rst_out_vec", out_vec, '0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end
    acc = v & in_ready & ~r;
    @(posedge clk);
    err_exp  = 1'b0;
    rst_prev = r;
    if (r) cur.delete();
    else if (acc) model_word(d, l);
    #1;
  endtask

  // mode 0/1: in_valid held high with out_ready = mode; mode 2: both randomized
  task automatic send_word(input logic [W-1:0] d, input logic l, input int mode);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 500) begin
      if (mode == 2) cycle(1'($urandom_range(1, 0)), d, l, 1'($urandom_range(1, 0)), 1'b0, acc);
      else           cycle(1'b1, d, l, 1'(mode), 1'b0, acc);
      n++;
    end
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: word %h not accepted within 500 cycles", d);
    end
  endtask

  task automatic send_frame(input int len, input int last_at, input int mode);
    for (int k = 0; k < len; k++) send_word($urandom, (k == last_at), mode);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'b0, ordy, 1'b0, acc);
  endtask

  task automatic do_reset();
    logic acc;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  // Monitor: compare registered outputs against scoreboard state every cycle
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        chk("frame_err", 32'(frame_err), 32'(err_exp));
        chk("frame_cnt", 32'(frame_cnt), 32'(cnt_exp));
        if (out_valid && exp_q.size() != 0) chkv("out_vec", out_vec, exp_q[0]);
        if (rst) begin
          exp_q.delete();
          cnt_exp = '0;
        end else if (out_valid && out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          cnt_exp = cnt_exp + 16'd1;
        end
      end
    end
  end

  initial begin
    logic acc;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    do_reset();
    mon_en = 1'b1;
    do_reset();

    // Ramp frame with immediate consumption
    for (int k = 0; k < N; k++) send_word(32'h3F80_0000 + 32'(k), (k == N - 1), 1);
    idle(3, 1'b1);
    chk("cnt_after_first", 32'(frame_cnt), 32'd1);

    // Fill both banks, stall on the third frame, release one vector
    send_frame(N, N - 1, 0);
    send_frame(N, N - 1, 0);
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0, acc);
      chk("stall_no_accept", 32'(acc), 32'd0);
    end
    cycle(1'b1, 32'hCAFE_0000, 1'b0, 1'b1, 1'b0, acc);
    chk("release_cycle_no_accept", 32'(acc), 32'd0);
    send_word(32'hCAFE_0000, 1'b0, 0);
    for (int k = 1; k < N; k++) send_word($urandom, (k == N - 1), 0);
    idle(2, 1'b0);
    chk("cnt_after_stall", 32'(frame_cnt), 32'd2);
    idle(5, 1'b1);

    // Early last on word 5, then a good frame
    send_frame(6, 5, 1);
    idle(2, 1'b1);
    send_frame(N, N - 1, 1);
    idle(3, 1'b1);

    // Missing last: still delivered, with an error pulse
    send_frame(N, -1, 1);
    idle(3, 1'b1);

    // Reset mid-frame, then with a vector pending
    send_frame(7, -1, 1);
    do_reset();
    send_frame(N, N - 1, 1);
    idle(3, 1'b1);
    send_frame(N, N - 1, 0);
    idle(3, 1'b0);
    do_reset();
    send_frame(N, N - 1, 1);
    idle(3, 1'b1);

    // Randomized handshakes over 1000 frames from a clean count
    do_reset();
    for (int f = 0; f < 1000; f++) send_frame(N, N - 1, 2);
    idle(10, 1'b1);
    chk("final_frame_cnt", 32'(frame_cnt), 32'd1000);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
